pcm_bridge_fetcher: RTL and testbench
=====================================

// Module: pcm_bridge_fetcher
// PURPOSE
//   Bus master on the SoC's 16-bit external bridge interface (address/byte_enable/read/write/acknowledge).
//   Streams a block of 16-bit PCM samples out of SDRAM into an internal FIFO.
//   Presents the samples to the downstream audio output stage on a valid/ready stream.
//   Started by a command pulse carrying a base address and a word count; raises done or error when finished.
// PARAMETERS
//   ADDR_W      26   bridge byte-address width
//   LEN_W       24   width of the word-count input
//   FIFO_DEPTH  16   sample FIFO entries; power of two, >= 2
//   TIMEOUT     255  max cycles to wait for acknowledge before aborting
// PORTS
//   clk_clk                   in   1       single clock; every register is on its rising edge
//   reset_reset               in   1       asynchronous, active-high reset
//   start                     in   1       one-cycle command pulse
//   base_addr                 in   ADDR_W  first byte address; bit 0 is ignored (forced even)
//   length                    in   LEN_W   number of 16-bit words to fetch
//   busy                      out  1       transfer in progress
//   done                      out  1       one-cycle pulse: all words accepted into the FIFO
//   error                     out  1       sticky acknowledge-timeout flag; cleared by the next accepted start
//   bridge_address            out  ADDR_W  read byte address
//   bridge_byte_enable        out  2       2'b11 while a read is active, else 2'b00
//   bridge_read               out  1       read request
//   bridge_write              out  1       tied 0
//   bridge_write_data         out  16      tied 0
//   bridge_acknowledge        in   1       bridge completes the access; read_data is valid in the same cycle
//   bridge_read_data          in   16      returned word
//   sample_data               out  16      head of the FIFO (show-ahead)
//   sample_valid              out  1       asserted when the FIFO is not empty
//   sample_ready              in   1       consumer accepts the head when ready and valid are both high
//   fifo_level                out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//   Reset values:
//     - all outputs 0; FSM in IDLE
//     - FIFO empty; pointers and counters 0
//   FSM state IDLE:
//     - start with length!=0: latch addr = {base_addr[ADDR_W-1:1],1'b0} and remaining = length
//     - clear error, set busy, go to ISSUE
//     - start with length==0: done pulses on the next cycle; busy stays 0
//     - start while busy=1 is ignored
//   FSM state ISSUE:
//     - if fifo_level < FIFO_DEPTH, assert bridge_read / byte_enable=11 / bridge_address=addr on the next edge
//     - clear the timeout counter, go to WAIT
//     - otherwise stall in ISSUE
//     - start -> 1st bridge_read high is 2 cycles (edge 1: IDLE->ISSUE, edge 2: read high)
//   FSM state WAIT:
//     - read, address and byte_enable are held stable until acknowledge is sampled high
//     - on ack: push bridge_read_data into the FIFO, drop read on the same edge
//     - on ack: addr += 2, wrapping modulo 2^ADDR_W; remaining -= 1
//     - remaining becomes 0 -> DONE, else -> ISSUE
//     - at most one read outstanding; with immediate acks, back-to-back reads are 2 cycles apart
//   Timeout:
//     - the counter increments each WAIT cycle without ack
//     - reaching TIMEOUT: drop read, set error, clear busy, go to IDLE; no push
//     - an ack arriving afterwards is ignored
//   FSM state DONE:
//     - done pulses high for 1 cycle, busy clears, go to IDLE
//     - FIFO contents keep draining independently
//   FIFO:
//     - sample_valid = (level!=0); sample_data = mem[rd_ptr] combinationally
//     - an ack-push at edge k makes the word visible on sample_valid/sample_data after edge k
//     - simultaneous push and pop: level unchanged, both pointers advance
//     - pointers wrap modulo FIFO_DEPTH
//     - ISSUE is gated on level, so a push can never see a full FIFO
//     - pop when empty is ignored
//   reset_reset asserted mid-transfer:
//     - everything returns to reset values immediately, including bridge_read
//     - FIFO contents are discarded
// TESTING
//   1. base_addr=0x000100, length=4, ack 1 cycle after each read, sample_ready=1
//      -> addresses 0x100,0x102,0x104,0x106; 4 samples in order; done 1 pulse; error=0
//   2. length=40, sample_ready=0 throughout
//      -> exactly 16 reads, fifo_level=16, bridge_read stays 0
//      -> raise ready: remaining 24 complete in order, done pulses
//   3. Ack withheld for 255 cycles
//      -> bridge_read drops, error=1, busy=0
//      -> a later start clears error and the transfer completes normally
//   4. base_addr=0x3FFFFFE, length=2
//      -> addresses 0x3FFFFFE then 0x0000000
//      -> base_addr=0x101 -> first address 0x100
//   5. length=0 -> done 1 cycle after start, no bridge_read
//      -> second start while busy has no effect on address or count
//   6. reset_reset pulsed during WAIT with 3 words buffered
//      -> bridge_read=0, sample_valid=0, fifo_level=0 at once; FSM in IDLE

Source files
------------

// File: rtl/pcm_bridge_fetcher.sv
// Bridge read master: streams a block of 16-bit PCM words from SDRAM
// into a show-ahead sample FIFO drained over a valid/ready stream.
module pcm_bridge_fetcher #(
  parameter int ADDR_W     = 26,
  parameter int LEN_W      = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [LEN_W-1:0]              length,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [ADDR_W-1:0]             bridge_address,
  output logic [1:0]                    bridge_byte_enable,
  output logic                          bridge_read,
  output logic                          bridge_write,
  output logic [15:0]                   bridge_write_data,
  input  logic                          bridge_acknowledge,
  input  logic [15:0]                   bridge_read_data,
  output logic [15:0]                   sample_data,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, DONE
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr;
  logic [LEN_W-1:0]   remaining;
  logic [TO_W-1:0]    tcnt;
  logic [15:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;
  logic               unused_base_bit0;

  assign unused_base_bit0  = base_addr[0];
  assign bridge_write      = 1'b0;
  assign bridge_write_data = 16'h0000;

  assign push         = (state == WAIT) && bridge_acknowledge;
  assign pop          = sample_ready && sample_valid;
  assign sample_valid = (fifo_level != '0);
  assign sample_data  = mem[rd_ptr];

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state              <= IDLE;
      addr               <= '0;
      remaining          <= '0;
      tcnt               <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      bridge_read        <= 1'b0;
      bridge_byte_enable <= 2'b00;
      bridge_address     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            error <= 1'b0;
            if (length != '0) begin
              addr      <= {base_addr[ADDR_W-1:1], 1'b0};
              remaining <= length;
              busy      <= 1'b1;
              state     <= ISSUE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // Only issue when a slot is free, so the ack push never overflows
          if (fifo_level < LVL_W'(FIFO_DEPTH)) begin
            bridge_read        <= 1'b1;
            bridge_byte_enable <= 2'b11;
            bridge_address     <= addr;
            tcnt               <= '0;
            state              <= WAIT;
          end
        end
        WAIT: begin
          if (bridge_acknowledge) begin
            bridge_read        <= 1'b0;
            bridge_byte_enable <= 2'b00;
            addr               <= addr + ADDR_W'(2);
            remaining          <= remaining - LEN_W'(1);
            state <= (remaining == LEN_W'(1)) ? DONE : ISSUE;
          end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
            bridge_read        <= 1'b0;
            bridge_byte_enable <= 2'b00;
            error              <= 1'b1;
            busy               <= 1'b0;
            state              <= IDLE;
          end else begin
            tcnt <= tcnt + TO_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 16'h0000;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= bridge_read_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + LVL_W'(1);
      end else if (pop && !push) begin
        fifo_level <= fifo_level - LVL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pcm_bridge_fetcher.sv
// Bench for pcm_bridge_fetcher: bridge responder, queue model of the
// fetched stream, per-cycle compare and directed transfer scenarios.
module tb_pcm_bridge_fetcher;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        start = 1'b0;
  logic [25:0] base_addr = '0;
  logic [23:0] length = '0;
  logic        busy, done, error;
  logic [25:0] bridge_address;
  logic [1:0]  bridge_byte_enable;
  logic        bridge_read, bridge_write;
  logic [15:0] bridge_write_data;
  logic        bridge_acknowledge = 1'b0;
  logic [15:0] bridge_read_data = '0;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic [4:0]  fifo_level;

  pcm_bridge_fetcher dut (
    .clk_clk            (clk_clk),
    .reset_reset        (reset_reset),
    .start              (start),
    .base_addr          (base_addr),
    .length             (length),
    .busy               (busy),
    .done               (done),
    .error              (error),
    .bridge_address     (bridge_address),
    .bridge_byte_enable (bridge_byte_enable),
    .bridge_read        (bridge_read),
    .bridge_write       (bridge_write),
    .bridge_write_data  (bridge_write_data),
    .bridge_acknowledge (bridge_acknowledge),
    .bridge_read_data   (bridge_read_data),
    .sample_data        (sample_data),
    .sample_valid       (sample_valid),
    .sample_ready       (sample_ready),
    .fifo_level         (fifo_level)
  );

  always #5 clk_clk = ~clk_clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word content the bridge returns for a given byte address
  function automatic logic [15:0] dfun(input logic [25:0] a);
    return a[16:1] + 16'h1234;
  endfunction

  // Model: expected next address, words left, FIFO contents
  logic [25:0] exp_addr = '0;
  int          exp_rem = 0;
  logic [15:0] q[$];
  logic [25:0] addr_log[$];
  logic [15:0] pop_log[$];
  int          ack_cnt = 0;
  int          pop_cnt = 0;
  int          rise_cnt = 0;
  logic        prev_read = 1'b0;

  always @(negedge clk_clk) begin
    if (reset_reset) begin
      q.delete();
      prev_read = 1'b0;
    end else begin
      check("level", {27'd0, fifo_level}, q.size());
      check("valid", {31'd0, sample_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) check("data", {16'd0, sample_data}, {16'd0, q[0]});
      check("byte_en", {30'd0, bridge_byte_enable},
            bridge_read ? 32'd3 : 32'd0);
      check("write_tie", {15'd0, bridge_write, bridge_write_data}, 32'd0);
      if (bridge_read) check("addr", {6'd0, bridge_address}, {6'd0, exp_addr});
      if (bridge_read && !prev_read) rise_cnt++;
      prev_read = bridge_read;
      if (q.size() != 0 && sample_ready) begin
        pop_log.push_back(q.pop_front());
        pop_cnt++;
      end
      if (bridge_read && bridge_acknowledge) begin
        check("ack_expected", {31'd0, exp_rem > 0}, 32'd1);
        q.push_back(dfun(exp_addr));
        addr_log.push_back(exp_addr);
        exp_addr = exp_addr + 26'd2;
        exp_rem--;
        ack_cnt++;
      end
    end
  end

  // Bridge responder: acks after ack_dly idle cycles when enabled
  bit ack_en = 1'b1;
  int ack_dly = 1;
  int wcnt = 0;

  always begin
    @(posedge clk_clk);
    #2;
    bridge_acknowledge = 1'b0;
    if (bridge_read && ack_en) begin
      if (wcnt >= ack_dly) begin
        bridge_acknowledge = 1'b1;
        bridge_read_data = dfun(bridge_address);
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [25:0] b, input int len, input bit model);
    tick(1);
    if (model) begin
      exp_addr = {b[25:1], 1'b0};
      exp_rem = len;
      addr_log.delete();
      pop_log.delete();
      ack_cnt = 0;
      pop_cnt = 0;
      rise_cnt = 0;
    end
    start = 1'b1;
    base_addr = b;
    length = len[23:0];
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (!done && n < maxc) begin
      tick(1);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    tick(1);
    check("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    tick(3);
    reset_reset = 1'b0;
    tick(1);
    check("rst_flags", {busy, done, error, bridge_read, sample_valid}, 32'd0);
    check("rst_level", {27'd0, fifo_level}, 32'd0);
    check("rst_addr", {6'd0, bridge_address}, 32'd0);

    // 1: short block, ack one cycle after each read
    sample_ready = 1'b1;
    ack_dly = 1;
    pulse(26'h100, 4, 1'b1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_read_lat0", {31'd0, bridge_read}, 32'd0);
    tick(1);
    check("t1_read_lat", {31'd0, bridge_read}, 32'd1);
    wait_done(100);
    check("t1_err", {30'd0, error, busy}, 32'd0);
    tick(5);
    check("t1_acks", ack_cnt, 32'd4);
    check("t1_pops", pop_cnt, 32'd4);
    check("t1_a0", {6'd0, addr_log[0]}, 32'h100);
    check("t1_a1", {6'd0, addr_log[1]}, 32'h102);
    check("t1_a3", {6'd0, addr_log[3]}, 32'h106);
    check("t1_s0", {16'd0, pop_log[0]}, 32'h12B4);

    // 2: consumer stalled, FIFO fills and reads stop
    sample_ready = 1'b0;
    ack_dly = 0;
    pulse(26'h1000, 40, 1'b1);
    tick(100);
    check("t2_acks16", ack_cnt, 32'd16);
    check("t2_reads16", rise_cnt, 32'd16);
    check("t2_full", {27'd0, fifo_level}, 32'd16);
    check("t2_read_low", {31'd0, bridge_read}, 32'd0);
    check("t2_busy", {31'd0, busy}, 32'd1);
    sample_ready = 1'b1;
    wait_done(400);
    tick(20);
    check("t2_acks", ack_cnt, 32'd40);
    check("t2_pops", pop_cnt, 32'd40);

    // 3: acknowledge withheld, timeout then recovery
    ack_en = 1'b0;
    pulse(26'h400, 3, 1'b1);
    n = 0;
    while (!bridge_read && n < 10) begin
      tick(1);
      n++;
    end
    n = 0;
    while (bridge_read && n < 400) begin
      tick(1);
      n++;
    end
    check("t3_timeout_cycles", n, 32'd255);
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_busy", {30'd0, busy, bridge_read}, 32'd0);
    check("t3_no_push", ack_cnt, 32'd0);
    ack_en = 1'b1;
    pulse(26'h500, 2, 1'b1);
    check("t3_err_clr", {31'd0, error}, 32'd0);
    wait_done(100);
    check("t3_acks", ack_cnt, 32'd2);
    tick(5);

    // 4: address wrap and odd base
    pulse(26'h3FFFFFE, 2, 1'b1);
    wait_done(100);
    check("t4_wrap0", {6'd0, addr_log[0]}, 32'h3FFFFFE);
    check("t4_wrap1", {6'd0, addr_log[1]}, 32'h0);
    tick(3);
    pulse(26'h101, 1, 1'b1);
    wait_done(100);
    check("t4_odd", {6'd0, addr_log[0]}, 32'h100);
    tick(5);

    // 5: zero length, and start while busy
    pulse(26'h300, 0, 1'b1);
    check("t5_done0", {30'd0, done, busy}, 32'd2);
    tick(1);
    check("t5_done0_pulse", {31'd0, done}, 32'd0);
    tick(5);
    check("t5_no_read", rise_cnt, 32'd0);
    ack_dly = 1;
    pulse(26'h200, 3, 1'b1);
    tick(2);
    pulse(26'h800, 5, 1'b0);
    wait_done(100);
    check("t5_acks", ack_cnt, 32'd3);
    check("t5_a2", {6'd0, addr_log[2]}, 32'h204);
    tick(5);

    // 6: reset mid-WAIT with three words buffered
    sample_ready = 1'b0;
    pulse(26'h600, 10, 1'b1);
    n = 0;
    while (fifo_level != 5'd3 && n < 100) begin
      tick(1);
      n++;
    end
    check("t6_level3", {27'd0, fifo_level}, 32'd3);
    ack_en = 1'b0;
    n = 0;
    while (!bridge_read && n < 10) begin
      tick(1);
      n++;
    end
    check("t6_in_wait", {31'd0, bridge_read}, 32'd1);
    #2;
    reset_reset = 1'b1;
    #1;
    check("t6_rst_read", {30'd0, bridge_read, sample_valid}, 32'd0);
    check("t6_rst_level", {27'd0, fifo_level}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    tick(2);
    reset_reset = 1'b0;
    tick(5);
    check("t6_idle", {29'd0, busy, bridge_read, sample_valid}, 32'd0);
    ack_en = 1'b1;
    sample_ready = 1'b1;
    pulse(26'h700, 2, 1'b1);
    wait_done(100);
    check("t6_recover", ack_cnt, 32'd2);
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
